montgomery_domain_converter: RTL and testbench

- Streaming converter that moves polynomial coefficients into or out of the Montgomery domain (R = 2^16), one coefficient per cycle.
- To-Montgomery mode: multiplies by R^2 mod q, then Montgomery-reduces, giving a·R mod q.
- From-Montgomery mode: multiplies by 1, then Montgomery-reduces, giving a·R^-1 mod q.
- Sits between the AXI coefficient buffers and the NTT/basemul datapath. Output is canonical [0, q), framed in blocks of KYBER_N coefficients.

---
 rtl/montgomery_domain_converter.sv | 111 +++++++++++
 tb/tb_montgomery_domain_converter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/montgomery_domain_converter.sv
// Streams 16-bit coefficients into (x R^2, reduce) or out of (x 1, reduce) the
// Montgomery domain, R = 2^16, one per cycle through three registered stages.
module montgomery_domain_converter #(
  parameter int MontgomeryR_QINV = 62209,
  parameter int KYBER_Q          = 3329,
  parameter int MONT_R2          = 1353,
  parameter int KYBER_N          = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iMode,
  input  logic        iValid,
  output logic        oReady_in,
  input  logic [15:0] iCoeffs,
  output logic        oValid,
  input  logic        iReady_out,
  output logic [15:0] oCoeffs,
  output logic        oLast,
  output logic        oBusy
);

  localparam int STAGES = 3;
  localparam int IDX_W  = $clog2(KYBER_N);
  localparam logic [IDX_W-1:0]  LP_LAST = IDX_W'(KYBER_N - 1);
  localparam logic signed [31:0] LP_Q   = 32'(KYBER_Q);
  localparam logic signed [31:0] LP_R2  = 32'(MONT_R2);
  localparam logic [15:0]        LP_Q16 = 16'(KYBER_Q);
  localparam logic [15:0]        LP_QINV = 16'(MontgomeryR_QINV);

  logic                    w_adv;
  logic                    w_accept;
  logic                    w_mode;
  logic                    w_in_last;
  logic signed [31:0]      w_a;
  logic signed [31:0]      w_k;
  logic signed [31:0]      w_p;
  logic [15:0]             w_u;
  logic signed [31:0]      w_u_s;
  logic signed [31:0]      w_t;
  logic signed [15:0]      w_r;
  logic [15:0]             w_canon;

  logic [STAGES:1]         r_vld_pipe;
  logic [STAGES:1]         r_last_pipe;
  logic [IDX_W-1:0]        r_in_idx;
  logic [IDX_W-1:0]        r_out_idx;
  logic                    r_mode;
  logic signed [31:0]      r_s1_p;
  logic signed [15:0]      r_s2_r;
  logic [15:0]             r_coeff;

  // One global advance: the whole pipe stalls only when the output is held.
  assign w_adv     = !r_vld_pipe[STAGES] || iReady_out;
  assign oReady_in = w_adv;
  assign w_accept  = iValid && w_adv;
  assign w_in_last = (r_in_idx == LP_LAST);

  // First beat of a block takes iMode live; later beats use the latched copy.
  assign w_mode = (r_in_idx == '0) ? iMode : r_mode;

  // S1 operand: multiplier picked per beat, so blocks of different modes overlap safely.
  assign w_a = {{16{iCoeffs[15]}}, iCoeffs};
  assign w_k = w_mode ? 32'sd1 : LP_R2;
  assign w_p = w_a * w_k;

  // S2 Montgomery reduction: t is a multiple of 2^16, so r = t[31:16] exactly.
  assign w_u   = 16'(r_s1_p[15:0] * LP_QINV);
  assign w_u_s = {{16{w_u[15]}}, w_u};
  assign w_t   = r_s1_p - w_u_s * LP_Q;
  assign w_r   = w_t[31:16];

  // S3 canonicalisation: r is in (-q, q), one conditional add suffices.
  assign w_canon = r_s2_r[15] ? (r_s2_r + LP_Q16) : r_s2_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe  <= '0;
      r_last_pipe <= '0;
      r_in_idx    <= '0;
      r_out_idx   <= '0;
      r_mode      <= 1'b0;
      r_s1_p      <= '0;
      r_s2_r      <= '0;
      r_coeff     <= '0;
    end else if (w_adv) begin
      r_vld_pipe  <= {r_vld_pipe[STAGES-1:1], iValid};
      r_last_pipe <= {r_last_pipe[STAGES-1:1], w_accept && w_in_last};
      r_s1_p      <= w_p;
      r_s2_r      <= w_r;
      r_coeff     <= w_canon;
      if (w_accept) begin
        r_in_idx <= w_in_last ? '0 : r_in_idx + IDX_W'(1);
        if (r_in_idx == '0) r_mode <= iMode;
      end
      if (r_vld_pipe[STAGES] && iReady_out)
        r_out_idx <= (r_out_idx == LP_LAST) ? '0 : r_out_idx + IDX_W'(1);
    end
  end

  // Reduction exactness and output framing invariants.
  always_ff @(posedge clk) begin
    if (!rst && r_vld_pipe[1]) assert (w_t[15:0] == 16'h0000);
    if (!rst && r_vld_pipe[STAGES]) assert (r_last_pipe[STAGES] == (r_out_idx == LP_LAST));
  end

  assign oValid  = r_vld_pipe[STAGES];
  assign oLast   = r_last_pipe[STAGES];
  assign oCoeffs = r_coeff;
  assign oBusy   = (|r_vld_pipe) || (r_in_idx != '0);

endmodule

// File: tb/tb_montgomery_domain_converter.sv
// Directed bench for montgomery_domain_converter: latency, known vectors,
// block framing, backpressure, mode latching, round trip and mid-block reset.
module tb_montgomery_domain_converter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iMode = 1'b0;
  logic        iValid = 1'b0;
  logic        oReady_in;
  logic [15:0] iCoeffs = '0;
  logic        oValid;
  logic        iReady_out = 1'b1;
  logic [15:0] oCoeffs;
  logic        oLast;
  logic        oBusy;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [15:0] c;
    logic        l;
  } beat_t;

  beat_t       got_q[$];
  beat_t       exp_q[$];
  logic [15:0] dat[256];
  logic [15:0] vin[4];
  logic [15:0] vexp[4];

  always #5 clk = ~clk;

  montgomery_domain_converter dut (
    .clk(clk), .rst(rst), .iMode(iMode), .iValid(iValid), .oReady_in(oReady_in),
    .iCoeffs(iCoeffs), .oValid(oValid), .iReady_out(iReady_out),
    .oCoeffs(oCoeffs), .oLast(oLast), .oBusy(oBusy)
  );

  // Output handshakes captured mid-cycle, away from the active edge.
  always @(negedge clk)
    if (!rst && oValid && iReady_out) got_q.push_back({oCoeffs, oLast});

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int mod_q(input int x);
    int r;
    r = x % 3329;
    if (r < 0) r += 3329;
    return r;
  endfunction

  // Reference: a*R mod q = a*2285, a*R^-1 mod q = a*169 (plain modular arithmetic).
  function automatic logic [15:0] conv(input logic [15:0] d, input logic m);
    int a;
    a = int'($signed(d));
    return m ? 16'(mod_q(mod_q(a) * 169)) : 16'(mod_q(mod_q(a) * 2285));
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic m);
    int t;
    iValid  = 1'b1;
    iCoeffs = d;
    iMode   = m;
    #1;
    t = 0;
    while (!oReady_in && t < 20) begin
      tick;
      t++;
    end
    chk("accept_ready", oReady_in, 1);
    tick;
  endtask

  task automatic stall5(input logic [15:0] d, input logic m);
    logic [15:0] held;
    iValid     = 1'b1;
    iCoeffs    = d;
    iMode      = m;
    iReady_out = 1'b0;
    #1;
    held = oCoeffs;
    chk("stall_valid_pre", oValid, 1);
    for (int k = 0; k < 5; k++) begin
      chk("stall_ready_in", oReady_in, 0);
      tick;
      chk("stall_coeff_hold", oCoeffs, held);
      chk("stall_valid_hold", oValid, 1);
    end
    iReady_out = 1'b1;
  endtask

  // Mode m is presented on beat 0; iMode is flipped from beat 50 on and must be ignored.
  task automatic run_block(input logic m, input int stall_at);
    logic md;
    for (int i = 0; i < 256; i++) begin
      md = (i < 50) ? m : ~m;
      if (i == stall_at) stall5(dat[i], md);
      exp_q.push_back({conv(dat[i], m), (i == 255)});
      send(dat[i], md);
    end
  endtask

  task automatic drain;
    iValid = 1'b0;
    repeat (8) tick;
  endtask

  task automatic compare(input int n_last);
    int lasts;
    chk("beat_count", got_q.size(), exp_q.size());
    lasts = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("coeff[%0d]", i), got_q[i].c, exp_q[i].c);
      chk($sformatf("last[%0d]", i), got_q[i].l, exp_q[i].l);
      if (got_q[i].l) lasts++;
    end
    chk("last_total", lasts, n_last);
  endtask

  task automatic do_reset;
    rst    = 1'b1;
    iValid = 1'b0;
    tick;
    rst = 1'b0;
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    // Reset state
    tick; tick;
    chk("rst_oValid", oValid, 0);
    chk("rst_oLast", oLast, 0);
    chk("rst_oBusy", oBusy, 0);
    chk("rst_oCoeffs", oCoeffs, 0);
    chk("rst_oReady_in", oReady_in, 1);
    rst = 1'b0;

    // Mode 0 known vectors, output exactly 3 cycles after acceptance
    iMode = 1'b0;
    vin  = '{16'd1, 16'd0, 16'hFFFF, 16'd3329};
    vexp = '{16'd2285, 16'd0, 16'd1044, 16'd0};
    for (int c = 0; c < 7; c++) begin
      iValid = (c < 4);
      if (c < 4) iCoeffs = vin[c];
      tick;
      if (c >= 2 && c <= 5) begin
        chk($sformatf("m0_valid[%0d]", c - 2), oValid, 1);
        chk($sformatf("m0_coeff[%0d]", c - 2), oCoeffs, vexp[c - 2]);
      end else begin
        chk($sformatf("m0_novalid_c%0d", c), oValid, 0);
      end
    end
    chk("partial_block_busy", oBusy, 1);
    do_reset;
    chk("reset_busy_clear", oBusy, 0);

    // Mode 1 known vectors
    iMode = 1'b1;
    vin  = '{16'd2285, 16'd1, 16'd3329, 16'h8000};
    vexp = '{16'd1, 16'd169, 16'd0, 16'd1664};
    for (int c = 0; c < 7; c++) begin
      iValid = (c < 4);
      if (c < 4) iCoeffs = vin[c];
      tick;
      if (c >= 2 && c <= 5) begin
        chk($sformatf("m1_valid[%0d]", c - 2), oValid, 1);
        chk($sformatf("m1_coeff[%0d]", c - 2), oCoeffs, vexp[c - 2]);
      end else begin
        chk($sformatf("m1_novalid_c%0d", c), oValid, 0);
      end
    end
    do_reset;

    // Block A (mode 0, stall at beat 100) then block B (mode 1) back to back
    for (int i = 0; i < 256; i++) dat[i] = 16'($urandom_range(0, 65535));
    dat[0] = 16'h8000;
    dat[1] = 16'h7FFF;
    run_block(1'b0, 100);
    for (int i = 0; i < 256; i++) dat[i] = 16'($urandom_range(0, 65535));
    run_block(1'b1, -1);
    drain;
    chk("ab_idle", oBusy, 0);
    compare(2);

    // Round trip: block A outputs back through mode 1 reproduce block A inputs mod q
    for (int i = 0; i < 256 && i < got_q.size(); i++) dat[i] = got_q[i].c;
    got_q.delete();
    exp_q.delete();
    run_block(1'b1, -1);
    drain;
    compare(1);
    got_q.delete();
    exp_q.delete();

    // Reset at beat 100 with three beats in flight
    for (int i = 0; i < 100; i++) send(16'($urandom_range(0, 65535)), 1'b0);
    chk("pre_reset_busy", oBusy, 1);
    chk("pre_reset_valid", oValid, 1);
    rst = 1'b1;
    tick;
    chk("midrst_oValid", oValid, 0);
    chk("midrst_oBusy", oBusy, 0);
    chk("midrst_oLast", oLast, 0);
    chk("midrst_oCoeffs", oCoeffs, 0);
    rst = 1'b0;
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < 256; i++) dat[i] = 16'($urandom_range(0, 65535));
    run_block(1'b1, -1);
    drain;
    compare(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
